// File: rtl/shifter_seq_if.sv
// Command/result bundle for shifter_seq: the master issues commands, the slave
// (the shifter) returns the result register and handshake status.
interface shifter_seq_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = 3
);
  logic             start;
  logic [2:0]       op;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] d_in;
  logic [WIDTH-1:0] d_out;
  logic             busy;
  logic             done;
  logic             carry;

  modport master (
    output start, op, shamt, d_in,
    input  d_out, busy, done, carry
  );

  modport slave (
    input  start, op, shamt, d_in,
    output d_out, busy, done, carry
  );
endinterface

// File: rtl/shifter_seq.sv
// Parametrised serial shifter: LOAD/LSL/LSR/ASR/ROL/ROR on a WIDTH-bit result
// register, one bit position per clock, with start/busy/done handshake and a
// carry flag holding the last bit shifted or rotated out.
module shifter_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = 3
) (
  input logic          clk,
  input logic          reset,
  shifter_seq_if.slave bus
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_LSL  = 3'b010,
    OP_LSR  = 3'b011,
    OP_ASR  = 3'b100,
    OP_ROL  = 3'b101,
    OP_ROR  = 3'b110,
    OP_RSV  = 3'b111
  } op_t;

  state_t           state;
  op_t              op_q;
  op_t              op_in;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] d_out_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] step_d;
  logic             step_c;

  assign op_in = op_t'(bus.op);

  // One-bit step of the latched operation applied to the current result.
  always_comb begin
    step_d = d_out_q;
    step_c = carry_q;
    unique case (op_q)
      OP_LSL: begin
        step_d = {d_out_q[WIDTH-2:0], 1'b0};
        step_c = d_out_q[WIDTH-1];
      end
      OP_LSR: begin
        step_d = {1'b0, d_out_q[WIDTH-1:1]};
        step_c = d_out_q[0];
      end
      OP_ASR: begin
        step_d = {d_out_q[WIDTH-1], d_out_q[WIDTH-1:1]};
        step_c = d_out_q[0];
      end
      OP_ROL: begin
        step_d = {d_out_q[WIDTH-2:0], d_out_q[WIDTH-1]};
        step_c = d_out_q[WIDTH-1];
      end
      OP_ROR: begin
        step_d = {d_out_q[0], d_out_q[WIDTH-1:1]};
        step_c = d_out_q[0];
      end
      default: ;
    endcase
  end

  // Control FSM and result/flag registers; done is a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      op_q    <= OP_NOP;
      cnt     <= '0;
      d_out_q <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            unique case (op_in)
              OP_LOAD: begin
                d_out_q <= bus.d_in;
                carry_q <= 1'b0;
                done_q  <= 1'b1;
              end
              OP_LSL, OP_LSR, OP_ASR, OP_ROL, OP_ROR: begin
                if (bus.shamt == '0) begin
                  done_q <= 1'b1;
                end else begin
                  op_q   <= op_in;
                  cnt    <= bus.shamt;
                  busy_q <= 1'b1;
                  state  <= SHIFT;
                end
              end
              default: done_q <= 1'b1;
            endcase
          end
        end
        SHIFT: begin
          d_out_q <= step_d;
          carry_q <= step_c;
          cnt     <= cnt - 1'b1;
          if (cnt == SHW'(1)) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.d_out = d_out_q;
  assign bus.carry = carry_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_shifter_seq.sv
// Self-checking bench for shifter_seq: 8-bit, 16-bit and 4-bit instances,
// a vector table of commands plus hand-written multi-cycle sequences.
module tb_shifter_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  shifter_seq_if #(.WIDTH(8),  .SHW(3)) b8 ();
  shifter_seq_if #(.WIDTH(16), .SHW(4)) b16 ();
  shifter_seq_if #(.WIDTH(4),  .SHW(3)) b4 ();

  shifter_seq #(.WIDTH(8),  .SHW(3)) dut8  (.clk(clk), .reset(reset), .bus(b8.slave));
  shifter_seq #(.WIDTH(16), .SHW(4)) dut16 (.clk(clk), .reset(reset), .bus(b16.slave));
  shifter_seq #(.WIDTH(4),  .SHW(3)) dut4  (.clk(clk), .reset(reset), .bus(b4.slave));

  // Shared command drive; each instance has its own start strobe.
  logic [2:0]  st;
  logic [2:0]  op_drv;
  logic [3:0]  sh_drv;
  logic [15:0] din_drv;

  assign b8.start  = st[0];
  assign b16.start = st[1];
  assign b4.start  = st[2];
  assign b8.op     = op_drv;
  assign b16.op    = op_drv;
  assign b4.op     = op_drv;
  assign b8.shamt  = sh_drv[2:0];
  assign b16.shamt = sh_drv;
  assign b4.shamt  = sh_drv[2:0];
  assign b8.d_in   = din_drv[7:0];
  assign b16.d_in  = din_drv;
  assign b4.d_in   = din_drv[3:0];

  logic [15:0] o_d    [3];
  logic        o_busy [3];
  logic        o_done [3];
  logic        o_c    [3];

  assign o_d[0] = {8'h00, b8.d_out};
  assign o_d[1] = b16.d_out;
  assign o_d[2] = {12'h000, b4.d_out};
  assign o_busy[0] = b8.busy;
  assign o_busy[1] = b16.busy;
  assign o_busy[2] = b4.busy;
  assign o_done[0] = b8.done;
  assign o_done[1] = b16.done;
  assign o_done[2] = b4.done;
  assign o_c[0] = b8.carry;
  assign o_c[1] = b16.carry;
  assign o_c[2] = b4.carry;

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one command to instance sel and check latency, result and done width.
  task automatic run(input int unsigned sel, input logic [2:0] op, input logic [3:0] sh,
                     input logic [15:0] din, input logic [15:0] ed, input logic ec,
                     input int unsigned lat, input string tag);
    int unsigned n;
    @(negedge clk);
    st[sel] = 1'b1;
    op_drv  = op;
    sh_drv  = sh;
    din_drv = din;
    @(negedge clk);
    st      = '0;
    din_drv = '0;
    op_drv  = 3'b001;
    n = 0;
    while (!o_done[sel] && n < 40) begin
      chk({tag, " busy"}, {31'd0, o_busy[sel]}, 32'd1);
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, n, lat);
    chk({tag, " busy_end"}, {31'd0, o_busy[sel]}, 32'd0);
    chk({tag, " d_out"}, {16'd0, o_d[sel]}, {16'd0, ed});
    chk({tag, " carry"}, {31'd0, o_c[sel]}, {31'd0, ec});
    @(negedge clk);
    chk({tag, " done_pulse"}, {31'd0, o_done[sel]}, 32'd0);
  endtask

  typedef struct {
    int unsigned sel;
    logic [2:0]  op;
    logic [3:0]  sh;
    logic [15:0] din;
    logic [15:0] ed;
    logic        ec;
    int unsigned lat;
    string       tag;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] lsl_exp [3];

    // Reset held for two cycles with a LOAD start pending: reset wins.
    reset   = 1'b1;
    st      = 3'b111;
    op_drv  = 3'b001;
    sh_drv  = 4'd3;
    din_drv = 16'hAAAA;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst d_out", {16'd0, o_d[i]}, 32'd0);
      chk("rst carry", {31'd0, o_c[i]}, 32'd0);
      chk("rst busy",  {31'd0, o_busy[i]}, 32'd0);
      chk("rst done",  {31'd0, o_done[i]}, 32'd0);
    end
    reset = 1'b0;
    st    = '0;
    @(negedge clk);
    chk("idle hold d_out", {16'd0, o_d[0]}, 32'd0);
    chk("idle hold done",  {31'd0, o_done[0]}, 32'd0);

    vecs.push_back('{0, 3'd1, 4'd0, 16'h00B5, 16'h00B5, 1'b0, 0, "load_b5"});
    vecs.push_back('{0, 3'd2, 4'd3, 16'h0000, 16'h00A8, 1'b1, 3, "lsl3"});
    vecs.push_back('{0, 3'd1, 4'd0, 16'h0080, 16'h0080, 1'b0, 0, "load_80"});
    vecs.push_back('{0, 3'd4, 4'd7, 16'h0000, 16'h00FF, 1'b0, 7, "asr7"});
    vecs.push_back('{0, 3'd3, 4'd0, 16'h0000, 16'h00FF, 1'b0, 0, "lsr0"});
    vecs.push_back('{0, 3'd0, 4'd5, 16'h0011, 16'h00FF, 1'b0, 0, "nop"});
    vecs.push_back('{0, 3'd7, 4'd2, 16'h0022, 16'h00FF, 1'b0, 0, "rsv"});
    vecs.push_back('{0, 3'd1, 4'd0, 16'h0001, 16'h0001, 1'b0, 0, "load_01"});
    vecs.push_back('{0, 3'd2, 4'd7, 16'h0000, 16'h0080, 1'b0, 7, "lsl7"});
    vecs.push_back('{0, 3'd3, 4'd7, 16'h0000, 16'h0001, 1'b0, 7, "lsr7"});
    vecs.push_back('{0, 3'd3, 4'd1, 16'h0000, 16'h0000, 1'b1, 1, "lsr1"});
    vecs.push_back('{0, 3'd0, 4'd0, 16'h0000, 16'h0000, 1'b1, 0, "nop_hold_c"});
    vecs.push_back('{0, 3'd5, 4'd0, 16'h0000, 16'h0000, 1'b1, 0, "rol0_hold_c"});
    vecs.push_back('{0, 3'd1, 4'd0, 16'h003C, 16'h003C, 1'b0, 0, "load_clr_c"});
    vecs.push_back('{0, 3'd5, 4'd7, 16'h0000, 16'h001E, 1'b0, 7, "rol7"});
    vecs.push_back('{0, 3'd1, 4'd0, 16'h0081, 16'h0081, 1'b0, 0, "load_81"});
    vecs.push_back('{0, 3'd6, 4'd7, 16'h0000, 16'h0003, 1'b0, 7, "ror7"});
    vecs.push_back('{1, 3'd1, 4'd0, 16'h8000, 16'h8000, 1'b0, 0, "w16_load"});
    vecs.push_back('{1, 3'd3, 4'd15, 16'h0000, 16'h0001, 1'b0, 15, "w16_lsr15"});
    vecs.push_back('{1, 3'd6, 4'd15, 16'h0000, 16'h0002, 1'b0, 15, "w16_ror15"});
    vecs.push_back('{1, 3'd1, 4'd0, 16'h8000, 16'h8000, 1'b0, 0, "w16_load2"});
    vecs.push_back('{1, 3'd4, 4'd15, 16'h0000, 16'hFFFF, 1'b0, 15, "w16_asr15"});
    vecs.push_back('{2, 3'd1, 4'd0, 16'h0009, 16'h0009, 1'b0, 0, "w4_load9"});
    vecs.push_back('{2, 3'd5, 4'd6, 16'h0000, 16'h0006, 1'b0, 6, "w4_rol6"});
    vecs.push_back('{2, 3'd3, 4'd5, 16'h0000, 16'h0000, 1'b0, 5, "w4_lsr5"});
    vecs.push_back('{2, 3'd1, 4'd0, 16'h000F, 16'h000F, 1'b0, 0, "w4_loadf"});
    vecs.push_back('{2, 3'd2, 4'd6, 16'h0000, 16'h0000, 1'b0, 6, "w4_lsl6"});
    vecs.push_back('{2, 3'd1, 4'd0, 16'h000A, 16'h000A, 1'b0, 0, "w4_loada"});
    vecs.push_back('{2, 3'd4, 4'd7, 16'h0000, 16'h000F, 1'b1, 7, "w4_asr7"});

    foreach (vecs[k])
      run(vecs[k].sel, vecs[k].op, vecs[k].sh, vecs[k].din, vecs[k].ed, vecs[k].ec,
          vecs[k].lat, vecs[k].tag);

    // LSL by 3 with every intermediate value checked.
    run(0, 3'd1, 4'd0, 16'h00B5, 16'h00B5, 1'b0, 0, "ld_b5_a");
    lsl_exp[0] = 8'h6A;
    lsl_exp[1] = 8'hD4;
    lsl_exp[2] = 8'hA8;
    @(negedge clk);
    st[0] = 1'b1; op_drv = 3'd2; sh_drv = 4'd3;
    @(negedge clk);
    st = '0;
    chk("lsl E0 d_out", {24'd0, b8.d_out}, 32'h00B5);
    chk("lsl E0 busy", {31'd0, b8.busy}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lsl step d_out", {24'd0, b8.d_out}, {24'd0, lsl_exp[i]});
      chk("lsl step done", {31'd0, b8.done}, (i == 2) ? 32'd1 : 32'd0);
      chk("lsl step busy", {31'd0, b8.busy}, (i == 2) ? 32'd0 : 32'd1);
    end
    chk("lsl final carry", {31'd0, b8.carry}, 32'd1);

    // ROL by 4 with an ignored LOAD at E2, then back-to-back ROR by 1.
    run(0, 3'd1, 4'd0, 16'h00B5, 16'h00B5, 1'b0, 0, "ld_b5_b");
    @(negedge clk);
    st[0] = 1'b1; op_drv = 3'd5; sh_drv = 4'd4;
    @(negedge clk);
    st = '0;
    chk("rol E0 d_out", {24'd0, b8.d_out}, 32'h00B5);
    @(negedge clk);
    chk("rol E1 d_out", {24'd0, b8.d_out}, 32'h006B);
    st[0] = 1'b1; op_drv = 3'd1; din_drv = 16'h0000;
    @(negedge clk);
    st = '0;
    chk("rol E2 d_out", {24'd0, b8.d_out}, 32'h00D6);
    chk("rol E2 busy", {31'd0, b8.busy}, 32'd1);
    @(negedge clk);
    chk("rol E3 d_out", {24'd0, b8.d_out}, 32'h00AD);
    @(negedge clk);
    chk("rol E4 d_out", {24'd0, b8.d_out}, 32'h005B);
    chk("rol E4 carry", {31'd0, b8.carry}, 32'd1);
    chk("rol E4 done", {31'd0, b8.done}, 32'd1);
    st[0] = 1'b1; op_drv = 3'd6; sh_drv = 4'd1;
    @(negedge clk);
    st = '0;
    chk("b2b accept busy", {31'd0, b8.busy}, 32'd1);
    chk("b2b done low", {31'd0, b8.done}, 32'd0);
    @(negedge clk);
    chk("ror1 d_out", {24'd0, b8.d_out}, 32'h00AD);
    chk("ror1 carry", {31'd0, b8.carry}, 32'd1);
    chk("ror1 done", {31'd0, b8.done}, 32'd1);
    @(negedge clk);
    chk("ror1 done fall", {31'd0, b8.done}, 32'd0);

    // Reset in the middle of LSR by 6: no done pulse, all registers cleared.
    run(0, 3'd1, 4'd0, 16'h00FF, 16'h00FF, 1'b0, 0, "ld_ff");
    @(negedge clk);
    st[0] = 1'b1; op_drv = 3'd3; sh_drv = 4'd6;
    @(negedge clk);
    st = '0;
    @(negedge clk);
    chk("lsr6 E1 d_out", {24'd0, b8.d_out}, 32'h007F);
    @(negedge clk);
    chk("lsr6 E2 d_out", {24'd0, b8.d_out}, 32'h003F);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst d_out", {24'd0, b8.d_out}, 32'd0);
    chk("midrst carry", {31'd0, b8.carry}, 32'd0);
    chk("midrst busy", {31'd0, b8.busy}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk("midrst no done", {31'd0, b8.done}, 32'd0);
      @(negedge clk);
    end
    chk("midrst stays 0", {24'd0, b8.d_out}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
